// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit pair per clock, LSB first, with a registered result and a done pulse.
// Optional signed-overflow output is enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             d_bit, br_nxt, last, accept;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    d_bit   = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
    br_nxt  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
    last    = (cnt_q == CW'(WIDTH - 1));
    // start is only honoured outside RUN, so an in-flight operation is never disturbed
    accept  = start && (state_q != RUN);
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    diff_d  = diff_q;
    br_d    = br_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      state_d = RUN;
      cnt_d   = '0;
      a_sh_d  = a;
      b_sh_d  = b;
      br_d    = bin;
    end else begin
      case (state_q)
        RUN: begin
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
          diff_d = {d_bit, diff_q[WIDTH-1:1]};
          br_d   = br_nxt;
          cnt_d  = cnt_q + CW'(1);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
          // on the final bit the shifters present the operand MSBs and d_bit is the result MSB
          if (last) ovf_d = (a_sh_q[0] != b_sh_q[0]) & (d_bit != a_sh_q[0]);
`endif
          if (last) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff = diff_q;
  assign bout = br_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against a plain-arithmetic reference model.
module tb_serial_subtractor;
  localparam int W  = 256;
  localparam int NR = 150;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout, busy, done;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .diff(diff), .bout(bout), .busy(busy), .done(done)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int i = 0; i < W; i += 32) r[i+:32] = $urandom;
    return r;
  endfunction

  // Reference: full-precision unsigned subtraction; the extra top bit is the borrow.
  task automatic chk_res(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    logic [W:0] full;
    full = {1'b0, ta} - {1'b0, tb_} - {{W{1'b0}}, tbin};
    chk({tag, ".diff"}, {1'b0, diff}, {1'b0, full[W-1:0]});
    chk({tag, ".bout"}, {{W{1'b0}}, bout}, {{W{1'b0}}, full[W]});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk({tag, ".ovf"}, {{W{1'b0}}, ovf},
        {{W{1'b0}}, (ta[W-1] != tb_[W-1]) && (full[W-1] != ta[W-1])});
`endif
  endtask

  // One isolated operation from IDLE, tracking latency, busy length and done pulses.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbin);
    int lat, bcnt, dcnt;
    @(negedge clk); a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0; bcnt = 0; dcnt = 0;
    for (int n = 1; n <= W + 4; n++) begin
      if (busy) bcnt++;
      if (done) begin dcnt++; if (lat == 0) lat = n; end
      if (n < W + 4) @(negedge clk);
    end
    chk({tag, ".lat"}, (W+1)'(lat), (W+1)'(W + 1));
    chk({tag, ".busy_len"}, (W+1)'(bcnt), (W+1)'(W));
    chk({tag, ".done_cnt"}, (W+1)'(dcnt), (W+1)'(1));
    chk_res(tag, ta, tb_, tbin);
  endtask

  initial begin
    logic [W-1:0] ra, rb, na, nb;
    logic         rbin, nbin;
    int           n, dcnt;

    #2;
    chk("rst.diff", {1'b0, diff}, '0);
    chk("rst.bout", {{W{1'b0}}, bout}, '0);
    chk("rst.busy", {{W{1'b0}}, busy}, '0);
    chk("rst.done", {{W{1'b0}}, done}, '0);
    @(negedge clk); rst = 1'b1;

    do_op("sub5m3", W'(5), W'(3), 1'b0);
    do_op("sub0m1", W'(0), W'(1), 1'b0);
    ra = rnd();
    do_op("aeqb_bin", ra, ra, 1'b1);
    do_op("rand_iso", rnd(), rnd(), 1'($urandom));

    // start pulses mid-RUN must not disturb the operation in flight
    ra = rnd(); rb = rnd(); rbin = 1'b1;
    @(negedge clk); a = ra; b = rb; bin = rbin; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int k = 1; k <= W + 4; k++) begin
      if (done) dcnt++;
      if (k == 10 || k == 50) begin a = rnd(); b = rnd(); bin = 1'b0; start = 1'b1; end
      else start = 1'b0;
      if (k < W + 4) @(negedge clk);
    end
    chk("ignore.done_cnt", (W+1)'(dcnt), (W+1)'(1));
    chk_res("ignore", ra, rb, rbin);

    // reset mid-RUN aborts silently
    @(negedge clk); a = rnd(); b = rnd(); bin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.busy", {{W{1'b0}}, busy}, '0);
    chk("abort.done", {{W{1'b0}}, done}, '0);
    chk("abort.diff", {1'b0, diff}, '0);
    chk("abort.bout", {{W{1'b0}}, bout}, '0);
    rst = 1'b1;
    dcnt = 0;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort.done_cnt", (W+1)'(dcnt), '0);
    do_op("after_abort", rnd(), rnd(), 1'b1);

    // start held high through DONE: next operation starts with no idle cycle
    ra = {1'b1, {(W-1){1'b0}}}; rb = W'(1);
    @(negedge clk); a = ra; b = rb; bin = 1'b0; start = 1'b1;
    n = 0;
    @(negedge clk); n = 1;
    while (!done && n < W + 3) begin @(negedge clk); n++; end
    chk("hold.lat", (W+1)'(n), (W+1)'(W + 1));
    chk_res("hold", ra, rb, 1'b0);
    @(negedge clk);
    chk("hold.b2b_busy", {{W{1'b0}}, busy}, (W+1)'(1));
    chk("hold.b2b_done", {{W{1'b0}}, done}, '0);
    start = 1'b0;
    while (!done && n < 2 * W + 6) begin @(negedge clk); n++; end
    chk("hold.second_done", {{W{1'b0}}, done}, (W+1)'(1));
    chk_res("hold2", ra, rb, 1'b0);
    @(negedge clk);

    // random back-to-back stream, each new start issued in the DONE cycle
    na = rnd(); nb = rnd(); nbin = 1'($urandom);
    if (($urandom % 8) == 0) nb = na;
    @(negedge clk); a = na; b = nb; bin = nbin; start = 1'b1;
    for (int i = 0; i < NR; i++) begin
      ra = na; rb = nb; rbin = nbin;
      @(negedge clk); start = 1'b0; n = 1;
      while (!done && n < W + 3) begin @(negedge clk); n++; end
      chk("rand.lat", (W+1)'(n), (W+1)'(W + 1));
      chk_res("rand", ra, rb, rbin);
      if (i < NR - 1) begin
        na = rnd(); nb = rnd(); nbin = 1'($urandom);
        if (($urandom % 8) == 0) nb = na;
        a = na; b = nb; bin = nbin; start = 1'b1;
      end
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
